// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, ALU class codes, mux selects, state encodings and control vector
package mips_ctrl_pkg;
    localparam int OPCODE_W   = 6;
    localparam int ALU_CODE_W = 2;
    localparam int STATE_W    = 4;

    localparam logic [OPCODE_W-1:0] OP_R     = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDIU = 6'b001001;

    localparam logic [ALU_CODE_W-1:0] ALU_CODE_MEM = 2'b00;
    localparam logic [ALU_CODE_W-1:0] ALU_CODE_BEQ = 2'b01;
    localparam logic [ALU_CODE_W-1:0] ALU_CODE_R   = 2'b10;

    localparam logic [1:0] SRC_B_RT     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_IF       = 4'd0,
        S_ID       = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IMM_EXEC = 4'd10,
        S_IMM_WB   = 4'd11
    } state_t;

    typedef struct packed {
        logic                  pc_write;
        logic                  pc_write_cond;
        logic [1:0]            pc_source;
        logic                  i_or_d;
        logic                  mem_read;
        logic                  mem_write;
        logic                  ir_write;
        logic                  mem_to_reg;
        logic                  reg_dst;
        logic                  reg_write;
        logic                  alu_src_a;
        logic [1:0]            alu_src_b;
        logic [ALU_CODE_W-1:0] alu_code;
    } ctrl_t;
endpackage

// File: rtl/mips_main_control_if.sv
// mips_main_control_if: opcode/mem_ready inputs and datapath control strobes
interface mips_main_control_if;
    import mips_ctrl_pkg::*;
    logic [OPCODE_W-1:0]   opcode;
    logic                  mem_ready;
    logic                  pc_write;
    logic                  pc_write_cond;
    logic [1:0]            pc_source;
    logic                  i_or_d;
    logic                  mem_read;
    logic                  mem_write;
    logic                  ir_write;
    logic                  mem_to_reg;
    logic                  reg_dst;
    logic                  reg_write;
    logic                  alu_src_a;
    logic [1:0]            alu_src_b;
    logic [ALU_CODE_W-1:0] alu_code_out;
    logic [STATE_W-1:0]    state_out;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_code_out, state_out
    );
    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_code_out, state_out
    );
endinterface

// File: rtl/mips_ctrl_out_dec.sv
// mips_ctrl_out_dec: combinational state -> control vector map
// IMM_EXEC/IMM_WB decode only exists when MIPS_CTRL_ADDIU_EN is defined
module mips_ctrl_out_dec
    import mips_ctrl_pkg::*;
(
    input  state_t i_state,
    input  logic   i_mem_ready,
    output ctrl_t  o_ctrl
);
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_IF: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRC_B_FOUR;
                o_ctrl.alu_code  = ALU_CODE_MEM;
                o_ctrl.pc_source = PC_SRC_ALU;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_ID: o_ctrl.alu_src_b = SRC_B_IMM_SH;
            S_MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRC_B_IMM;
            end
            S_MEM_RD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRC_B_RT;
                o_ctrl.alu_code  = ALU_CODE_R;
            end
            S_R_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRC_B_RT;
                o_ctrl.alu_code      = ALU_CODE_BEQ;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PC_SRC_JUMP;
            end
`ifdef MIPS_CTRL_ADDIU_EN
            S_IMM_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRC_B_IMM;
            end
            S_IMM_WB: o_ctrl.reg_write = 1'b1;
`endif
            default: o_ctrl = '0;
        endcase
    end
endmodule

// File: rtl/mips_main_control.sv
// mips_main_control: multicycle MIPS main control FSM (next-state logic + reset gating)
// Define MIPS_CTRL_ADDIU_EN to add the ADDIU IMM_EXEC/IMM_WB path
module mips_main_control
    import mips_ctrl_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    mips_main_control_if.master bus
);
    state_t r_state;
    ctrl_t  w_ctrl;
    ctrl_t  w_out;

    mips_ctrl_out_dec u_dec (
        .i_state     (r_state),
        .i_mem_ready (bus.mem_ready),
        .o_ctrl      (w_ctrl)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= S_IF;
        else begin
            case (r_state)
                S_IF:       if (bus.mem_ready) r_state <= S_ID;
                S_ID: begin
                    case (bus.opcode)
                        OP_LW, OP_SW: r_state <= S_MEM_ADDR;
                        OP_R:         r_state <= S_EXEC;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_J:         r_state <= S_JUMP;
`ifdef MIPS_CTRL_ADDIU_EN
                        OP_ADDIU:     r_state <= S_IMM_EXEC;
`endif
                        default:      r_state <= S_IF;
                    endcase
                end
                S_MEM_ADDR: r_state <= (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   if (bus.mem_ready) r_state <= S_MEM_WB;
                S_MEM_WR:   if (bus.mem_ready) r_state <= S_IF;
                S_EXEC:     r_state <= S_R_WB;
`ifdef MIPS_CTRL_ADDIU_EN
                S_IMM_EXEC: r_state <= S_IMM_WB;
`endif
                default:    r_state <= S_IF;
            endcase
        end
    end

    // Reset dominates combinationally so no strobe leaks while rst is low
    assign w_out             = rst ? w_ctrl : '0;
    assign bus.state_out     = rst ? r_state : '0;
    assign bus.pc_write      = w_out.pc_write;
    assign bus.pc_write_cond = w_out.pc_write_cond;
    assign bus.pc_source     = w_out.pc_source;
    assign bus.i_or_d        = w_out.i_or_d;
    assign bus.mem_read      = w_out.mem_read;
    assign bus.mem_write     = w_out.mem_write;
    assign bus.ir_write      = w_out.ir_write;
    assign bus.mem_to_reg    = w_out.mem_to_reg;
    assign bus.reg_dst       = w_out.reg_dst;
    assign bus.reg_write     = w_out.reg_write;
    assign bus.alu_src_a     = w_out.alu_src_a;
    assign bus.alu_src_b     = w_out.alu_src_b;
    assign bus.alu_code_out  = w_out.alu_code;
endmodule

// File: tb/tb_mips_main_control.sv
// tb_mips_main_control: random instruction stream vs. per-instruction state-path model with scoreboard
module tb_mips_main_control;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [19:0] exp_q[$];
    int passed = 0;
    int total = 0;

    mips_main_control_if bus();
    mips_main_control dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Expected output vector for a given state straight from the state table
    function automatic logic [19:0] spec_out(int s, bit rdy);
        logic pw = 0, pwc = 0, iod = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, asa = 0;
        logic [1:0] ps = 0, asb = 0, ac = 0;
        case (s)
            0:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iod = 1; end
            6:  begin asa = 1; ac = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; ac = 2'b01; pwc = 1; ps = 2'b01; end
            9:  begin pw = 1; ps = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, ps, iod, mr, mw, irw, m2r, rd, rw, asa, asb, ac, 4'(s)};
    endfunction

    task automatic cyc(bit r, bit rdy, logic [5:0] op, logic [19:0] e);
        @(posedge clk);
        #1;
        rst = r;
        bus.mem_ready = rdy;
        bus.opcode = op;
        exp_q.push_back(e);
    endtask

    task automatic step(int s, bit rdy, logic [5:0] op);
        cyc(1'b1, rdy, op, spec_out(s, rdy));
    endtask

    task automatic run_instr(logic [5:0] op, int w_if, int w_mem);
        int seq[$];
        for (int i = 0; i < w_if; i++) step(0, 1'b0, 6'($urandom));
        step(0, 1'b1, 6'($urandom));
        step(1, 1'($urandom), op);
        case (op)
            6'b100011: seq = {2, 3, 4};
            6'b101011: seq = {2, 5};
            6'b000000: seq = {6, 7};
            6'b000100: seq = {8};
            6'b000010: seq = {9};
`ifdef MIPS_CTRL_ADDIU_EN
            6'b001001: seq = {10, 11};
`endif
            default:   seq = {};
        endcase
        foreach (seq[k]) begin
            if (seq[k] == 3 || seq[k] == 5) begin
                for (int i = 0; i < w_mem; i++) step(seq[k], 1'b0, op);
                step(seq[k], 1'b1, op);
            end else
                step(seq[k], 1'($urandom), op);
        end
    endtask

    initial begin
        logic [19:0] e;
        logic [19:0] a;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d, bus.mem_read,
                     bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
                     bus.alu_src_a, bus.alu_src_b, bus.alu_code_out, bus.state_out};
                total++;
                if (a === e) passed++;
                else $display("FAIL ctrl_vec t=%0t: got %05h expected %05h", $time, a, e);
            end
        end
    end

    initial begin
        logic [5:0] ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001001};
        logic [5:0] op;
        bus.mem_ready = 1'b0;
        bus.opcode = 6'b0;
        cyc(1'b0, 1'b0, 6'b0, 20'h0);
        cyc(1'b0, 1'b1, 6'h3f, 20'h0);
        run_instr(6'b100011, 0, 0);
        run_instr(6'b101011, 4, 3);
        run_instr(6'b000000, 0, 0);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(6'b001001, 0, 0);
        run_instr(6'b000010, 1, 0);
        // LW aborted by reset while waiting in MEM_RD
        step(0, 1'b1, 6'b100011);
        step(1, 1'b1, 6'b100011);
        step(2, 1'b0, 6'b100011);
        step(3, 1'b0, 6'b100011);
        step(3, 1'b0, 6'b100011);
        repeat (3) cyc(1'b0, 1'($urandom), 6'($urandom), 20'h0);
        run_instr(6'b000000, 0, 0);
        for (int n = 0; n < 200; n++) begin
            int pick = $urandom_range(0, 6);
            op = (pick == 6) ? 6'($urandom) : ops[pick];
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mips_main_control.md
Name: mips_main_control

Overview:
- Multicycle MIPS main control FSM. It decodes the instruction opcode and drives the datapath control strobes.
- It generates the 2-bit ALU class code (00 add for load/store/address, 01 sub for branch compare, 10 R-type funct-decoded) consumed by the downstream ALU control decoder.
- It sits between the instruction register and the datapath, and paces instruction fetch and memory access with a memory ready handshake.

Parameters:
- OPCODE_W, 6, opcode field width
- ALU_CODE_W, 2, width of ALU class code output
- STATE_W, 4, state register width

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  synchronous, active-low reset (rst==0 sampled at clk rising edge resets)
- opcode  input  OPCODE_W  IR[31:26], valid from ID onward
- mem_ready  input  1  memory has completed the current read/write this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero
- pc_source  output  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- i_or_d  output  1  memory address select: 0 PC, 1 ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  load instruction register
- mem_to_reg  output  1  regfile write data: 0 ALUOut, 1 MDR
- reg_dst  output  1  write register: 0 rt, 1 rd
- reg_write  output  1  regfile write enable
- alu_src_a  output  1  0 PC, 1 rs
- alu_src_b  output  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_code_out  output  ALU_CODE_W  ALU class code to ALU control
- state_out  output  STATE_W  current state, debug only

Behaviour:
- Moore FSM. All outputs decode from the current state; mem_ready additionally gates the IF strobes. Unlisted outputs are 0 in every state.
- Reset: while rst==0, every output is forced to 0. The next rising edge with rst==0 loads state IF. Reset asserted mid-instruction aborts it; no partial write survives past the reset edge.
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDIU 001001 (ADDIU only when the optional feature is enabled).
- States and transitions:
  - IF(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_code=00, pc_source=00.
    - If mem_ready=1: ir_write=1, pc_write=1, next ID.
    - Else: ir_write=0, pc_write=0, stay in IF.
  - ID(1): alu_src_a=0, alu_src_b=11, alu_code=00. Next state by opcode:
    - LW/SW -> MEM_ADDR
    - R -> EXEC
    - BEQ -> BRANCH
    - J -> JUMP
    - any other opcode -> IF (instruction retired as NOP; PC already advanced)
  - MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_code=00. Next MEM_RD (LW) or MEM_WR (SW).
  - MEM_RD(3): mem_read=1, i_or_d=1. Hold until mem_ready=1, then MEM_WB.
  - MEM_WB(4): reg_write=1, mem_to_reg=1, reg_dst=0. Next IF.
  - MEM_WR(5): mem_write=1, i_or_d=1. Hold until mem_ready=1, then IF.
  - EXEC(6): alu_src_a=1, alu_src_b=00, alu_code=10. Next R_WB.
  - R_WB(7): reg_write=1, reg_dst=1, mem_to_reg=0. Next IF.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_code=01, pc_write_cond=1, pc_source=01. Next IF.
  - JUMP(9): pc_write=1, pc_source=10. Next IF.
- mem_read/mem_write stay asserted continuously while waiting for mem_ready; there is no timeout.
- mem_ready is ignored in every state except IF, MEM_RD and MEM_WR.
- Cycle counts with mem_ready=1 on first request:
  - LW 5 cycles
  - SW 4 cycles
  - R 4 cycles
  - BEQ 3 cycles
  - J 3 cycles
  - unknown opcode 2 cycles
- Unused state encodings (including 10/11 when the optional feature is disabled): all outputs 0, next IF.

Optional Feature:
- Macro MIPS_CTRL_ADDIU_EN.
- Defined: ID routes ADDIU to IMM_EXEC(10), then IMM_WB(11), then IF.
  - IMM_EXEC: alu_src_a=1, alu_src_b=10, alu_code=00.
  - IMM_WB: reg_write=1, reg_dst=0, mem_to_reg=0.
- Not defined: ADDIU is treated as an unknown opcode (ID -> IF), and encodings 10/11 are unreachable.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants
  - ALU class codes ALU_CODE_MEM=00, ALU_CODE_BEQ=01, ALU_CODE_R=10
  - state encodings
  - ALU_SRC_B select constants
- One sub-module, mips_ctrl_out_dec: purely combinational map from state and mem_ready to the control vector. It keeps the FSM file to next-state logic only.

Test Plan:
- Reset: hold rst=0 for 3 cycles mid-MEM_RD -> all outputs 0 during reset; state_out=0 on first cycle after rst=1; mem_read=1, i_or_d=0.
- LW: opcode=100011, mem_ready=1 always -> state sequence 0,1,2,3,4,0; alu_code_out=00 in states 0–2; reg_write=1 and mem_to_reg=1 only in state 4.
- Memory wait: SW with mem_ready=0 for 4 cycles in IF and 3 in MEM_WR -> ir_write pulses exactly once, when mem_ready rises; mem_write high for 4 cycles; return to IF.
- R-type then BEQ back-to-back -> alu_code_out=10 in EXEC; reg_dst=1 in R_WB; alu_code_out=01 and pc_write_cond=1 in BRANCH; total 7 cycles.
- Unknown opcode 111111 -> 0,1,0; reg_write, mem_write and pc_write_cond never asserted.
- With MIPS_CTRL_ADDIU_EN: opcode 001001 -> 0,1,10,11,0; alu_src_b=10 in state 10; reg_write=1 and reg_dst=0 in state 11. Without the macro -> 0,1,0.
